// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter: merges NUM_INPUTS execute-unit result streams onto one
// registered writeback slot. Round-robin between packets; once a packet's
// first non-eop beat is granted, the arbiter locks onto that input until the
// eop beat is taken.
// Optional feature: define VX_WB_ARB_PERF_EN to add the perf_stalls counter.
module vx_wb_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_WIDTH  = 44,
  parameter int DATAW       = UUID_WIDTH + NW_BITS + NUM_THREADS + NR_BITS + 1 + 1 + NUM_THREADS*XLEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_INPUTS-1:0]         in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0]   in_data,
  output logic [NUM_INPUTS-1:0]         in_ready,
  output logic                          wb_valid,
  output logic [UUID_WIDTH-1:0]         wb_uuid,
  output logic [NW_BITS-1:0]            wb_wid,
  output logic [NUM_THREADS-1:0]        wb_tmask,
  output logic [NR_BITS-1:0]            wb_rd,
  output logic                          wb_eop,
  output logic [NUM_THREADS*XLEN-1:0]   wb_data,
`ifdef VX_WB_ARB_PERF_EN
  output logic [31:0]                   perf_stalls,
`endif
  output logic [31:0]                   commit_count
);

  localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Field layout MSB->LSB must match the packed in_data slices.
  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [NR_BITS-1:0]          rd;
    logic                        wb;
    logic                        eop;
    logic [NUM_THREADS*XLEN-1:0] data;
  } beat_t;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  int            rr_idx;
  beat_t         in_beat [NUM_INPUTS];
  beat_t         sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign in_beat[gi] = beat_t'(in_data[gi*DATAW +: DATAW]);
    end
  endgenerate

  // Grant selection: locked owner only, else first valid input scanning from ptr.
  // The scan runs lowest-priority first so the highest-priority hit lands last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    if (reset) begin
      if (state == LOCKED) begin
        grant_vld = in_valid[owner];
        grant_idx = owner;
      end else begin
        for (int k = NUM_INPUTS-1; k >= 0; k--) begin
          rr_idx = (int'(ptr) + k) % NUM_INPUTS;
          if (in_valid[rr_idx]) begin
            grant_vld = 1'b1;
            grant_idx = PW'(rr_idx);
          end
        end
      end
    end
  end

  assign in_ready = grant_vld ? (NUM_INPUTS'(1) << grant_idx) : '0;
  assign sel      = in_beat[grant_idx];

  // Lock/pointer next state: eop releases and advances ptr, non-eop locks.
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    if (grant_vld) begin
      if (sel.eop) begin
        state_n = IDLE;
        ptr_n   = PW'((int'(grant_idx) + 1) % NUM_INPUTS);
      end else begin
        state_n = LOCKED;
        owner_n = grant_idx;
      end
    end
  end

  // Arbiter state registers; reset abandons any held lock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
    end
  end

  // Writeback strobe and commit counter; wb=0 beats are consumed silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      commit_count <= '0;
    end else begin
      wb_valid <= grant_vld & sel.wb;
      if (grant_vld && sel.eop)
        commit_count <= commit_count + 32'd1;
    end
  end

  // Payload capture; left stale when nothing is accepted.
  always_ff @(posedge clk) begin
    if (grant_vld) begin
      wb_uuid  <= sel.uuid;
      wb_wid   <= sel.wid;
      wb_tmask <= sel.tmask;
      wb_rd    <= sel.rd;
      wb_eop   <= sel.eop;
      wb_data  <= sel.data;
    end
  end

`ifdef VX_WB_ARB_PERF_EN
  // Stall cycles: some input is offering a beat that is not taken; saturates.
  always_ff @(posedge clk) begin
    if (!reset)
      perf_stalls <= '0;
    else if (|(in_valid & ~in_ready) && perf_stalls != 32'hFFFF_FFFF)
      perf_stalls <= perf_stalls + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed bench for vx_wb_arbiter: reset, round-robin, wb=0 beats, packet
// lock with bubbles, reset mid-packet, and the optional stall counter.
module tb_vx_wb_arbiter;
  localparam int NI = 4, NT = 4, XL = 32, NW = 2, NR = 6, UW = 44;
  localparam int DW = UW + NW + NT + NR + 2 + NT*XL;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NI-1:0]      in_valid = '0;
  logic [NI*DW-1:0]   in_data = '0;
  logic [NI-1:0]      in_ready;
  logic               wb_valid;
  logic [UW-1:0]      wb_uuid;
  logic [NW-1:0]      wb_wid;
  logic [NT-1:0]      wb_tmask;
  logic [NR-1:0]      wb_rd;
  logic               wb_eop;
  logic [NT*XL-1:0]   wb_data;
  logic [31:0]        commit_count;
`ifdef VX_WB_ARB_PERF_EN
  logic [31:0]        perf_stalls;
`endif

  int n_chk = 0;
  int n_fail = 0;

  vx_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
    .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_eop(wb_eop), .wb_data(wb_data),
`ifdef VX_WB_ARB_PERF_EN
    .perf_stalls(perf_stalls),
`endif
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [UW-1:0] u, input logic [NR-1:0] rd,
                                       input logic wb, input logic eop);
    return {u, u[NW-1:0], {NT{1'b1}}, rd, wb, eop, {NT{u[31:0]}}};
  endfunction

  task automatic drive(input int i, input logic v, input logic [UW-1:0] u,
                       input logic wb, input logic eop);
    in_valid[i] = v;
    in_data[i*DW +: DW] = mk(u, NR'(i), wb, eop);
  endtask

  // Check grant after inputs settle, then advance one clock (to posedge+1).
  task automatic cyc(input string tag, input logic [NI-1:0] er);
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'(er));
    @(posedge clk);
    #1;
  endtask

  // Check registered outputs of the beat accepted in the previous cycle.
  task automatic outs(input string tag, input logic v, input logic [UW-1:0] u,
                      input logic [31:0] cc);
    chk({tag, " wb_valid"}, 64'(wb_valid), 64'(v));
    chk({tag, " commit_count"}, 64'(commit_count), 64'(cc));
    if (v) begin
      chk({tag, " wb_uuid"}, 64'(wb_uuid), 64'(u));
      chk({tag, " wb_data"}, 64'(wb_data[NT*XL-1 -: 32]), 64'(u[31:0]));
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset with all inputs valid: no grants, outputs cleared.
    for (int i = 0; i < NI; i++) drive(i, 1'b1, UW'(32'h10 + i), 1'b1, 1'b1);
    reset = 1'b0;
    cyc("rst", 4'b0000);
    outs("rst", 1'b0, '0, 32'd0);
    reset = 1'b1;

    // Round-robin over four single-beat packets.
    for (int k = 0; k < 5; k++) begin
      cyc("rr", NI'(1) << (k % NI));
      outs("rr", 1'b1, UW'(32'h10 + (k % NI)), 32'(k + 1));
    end
    chk("rr wb_rd", 64'(wb_rd), 64'd0);

    // wb=0 beat: consumed and committed, no writeback strobe. ptr 1 -> 0.
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, 1'b0, 1'b0);
    drive(3, 1'b1, UW'(32'h30), 1'b0, 1'b1);
    cyc("wb0", 4'b1000);
    outs("wb0", 1'b0, '0, 32'd6);

    // Advance ptr to 1, then 3-beat packet from input 1 with 0 and 2 waiting.
    drive(3, 1'b0, '0, 1'b0, 1'b0);
    drive(0, 1'b1, UW'(32'h40), 1'b1, 1'b1);
    cyc("pre", 4'b0001);
    outs("pre", 1'b1, UW'(32'h40), 32'd7);
    drive(2, 1'b1, UW'(32'h42), 1'b1, 1'b1);
    drive(1, 1'b1, UW'(32'h51), 1'b1, 1'b0);
    cyc("pkt1", 4'b0010);
    outs("pkt1", 1'b1, UW'(32'h51), 32'd7);
    chk("pkt1 wb_eop", 64'(wb_eop), 64'd0);
    drive(1, 1'b1, UW'(32'h52), 1'b1, 1'b0);
    cyc("pkt2", 4'b0010);
    outs("pkt2", 1'b1, UW'(32'h52), 32'd7);
    drive(1, 1'b1, UW'(32'h53), 1'b1, 1'b1);
    cyc("pkt3", 4'b0010);
    outs("pkt3", 1'b1, UW'(32'h53), 32'd8);
    chk("pkt3 wb_eop", 64'(wb_eop), 64'd1);
    chk("pkt3 wb_rd", 64'(wb_rd), 64'd1);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    cyc("next", 4'b0100);
    outs("next", 1'b1, UW'(32'h42), 32'd9);
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(2, 1'b0, '0, 1'b0, 1'b0);
    cyc("idle", 4'b0000);
    outs("idle", 1'b0, '0, 32'd9);

    // Lock with owner bubbles (ptr=3): input 0 must wait for owner's eop.
    drive(3, 1'b1, UW'(32'h61), 1'b1, 1'b0);
    drive(0, 1'b1, UW'(32'h70), 1'b1, 1'b1);
    cyc("lk", 4'b1000);
    outs("lk", 1'b1, UW'(32'h61), 32'd9);
    drive(3, 1'b0, '0, 1'b0, 1'b0);
    cyc("bub1", 4'b0000);
    outs("bub1", 1'b0, '0, 32'd9);
    cyc("bub2", 4'b0000);
    outs("bub2", 1'b0, '0, 32'd9);
    drive(3, 1'b1, UW'(32'h62), 1'b1, 1'b1);
    cyc("own", 4'b1000);
    outs("own", 1'b1, UW'(32'h62), 32'd10);
    drive(3, 1'b0, '0, 1'b0, 1'b0);
    cyc("rel", 4'b0001);
    outs("rel", 1'b1, UW'(32'h70), 32'd11);

    // Reset mid-packet (ptr=1): lock abandoned, input 0 wins after release.
    drive(0, 1'b1, UW'(32'h71), 1'b1, 1'b1);
    drive(1, 1'b1, UW'(32'h81), 1'b1, 1'b0);
    cyc("mb1", 4'b0010);
    outs("mb1", 1'b1, UW'(32'h81), 32'd11);
    drive(1, 1'b1, UW'(32'h82), 1'b1, 1'b0);
    reset = 1'b0;
    cyc("mrst", 4'b0000);
    outs("mrst", 1'b0, '0, 32'd0);
    reset = 1'b1;
    drive(1, 1'b1, UW'(32'h83), 1'b1, 1'b0);
    cyc("post", 4'b0001);
    outs("post", 1'b1, UW'(32'h71), 32'd1);

`ifdef VX_WB_ARB_PERF_EN
    // Stall counter: two contenders for four cycles -> one stall each cycle.
    for (int i = 0; i < NI; i++) drive(i, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("prst", 4'b0000);
    chk("prst perf_stalls", 64'(perf_stalls), 64'd0);
    reset = 1'b1;
    drive(0, 1'b1, UW'(32'h90), 1'b1, 1'b1);
    drive(1, 1'b1, UW'(32'h91), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc("perf", NI'(1) << (k % 2));
      outs("perf", 1'b1, UW'(32'h90 + (k % 2)), 32'(k + 1));
    end
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    chk("perf_stalls", 64'(perf_stalls), 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_wb_arbiter.md
VX_WB_ARBITER -- requirements
Module: vx_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of execute-unit result streams merged onto one writeback slot.
REQ-002 SHALL have parameter NUM_THREADS, default 4: lanes per result.
REQ-003 SHALL have parameter XLEN, default 32: bits per lane datum.
REQ-004 SHALL have parameters NW_BITS, default 2 (warp id width), and NR_BITS, default 6 (register id width).
REQ-005 SHALL have parameter UUID_WIDTH, default 44: instruction uuid width.
REQ-006 SHALL define DATAW = UUID_WIDTH+NW_BITS+NUM_THREADS+NR_BITS+1+1+NUM_THREADS*XLEN; field order MSB->LSB: uuid, wid, tmask, rd, wb, eop, data.
REQ-007 SHALL have ports clk (in, 1, clock) and reset (in, 1, reset); clock and reset are single-clock, synchronous, active-low.
REQ-008 SHALL have port in_valid  in  NUM_INPUTS  per-input result valid.
REQ-009 SHALL have port in_data  in  NUM_INPUTS*DATAW  per-input result, input i at slice [i*DATAW +: DATAW].
REQ-010 SHALL have port in_ready  out  NUM_INPUTS  per-input accept.
REQ-011 SHALL have port wb_valid  out  1  writeback strobe.
REQ-012 SHALL have ports wb_uuid, wb_wid, wb_tmask, wb_rd, wb_eop, wb_data  out  field widths per REQ-006  registered writeback payload.
REQ-013 SHALL have port commit_count  out  32  count of accepted eop beats.

Function
REQ-014 Input handshake: beat transferred on input i when in_valid[i] && in_ready[i]; the writeback side has no backpressure.
REQ-015 At most one in_ready bit SHALL be high per cycle; in_ready[i] high only if in_valid[i] high (grant = ready, combinational from valid and state).
REQ-016 Arbitration: round-robin; priority pointer ptr (log2 NUM_INPUTS bits) gives highest priority to input ptr, then ptr+1, ... wrapping modulo NUM_INPUTS.
REQ-017 After a granted beat with eop=1 from input g, ptr SHALL become (g+1) mod NUM_INPUTS; otherwise ptr unchanged.
REQ-018 Packet lock: two states IDLE, LOCKED; a granted beat with eop=0 moves IDLE->LOCKED recording owner g; in LOCKED only input owner may be granted, regardless of other valids.
REQ-019 LOCKED->IDLE on a granted owner beat with eop=1; a LOCKED owner with in_valid low SHALL produce no grant (bubble) and hold state.
REQ-020 Latency: a beat accepted in cycle N SHALL appear on wb_* in cycle N+1 with wb_valid=1 iff its wb field is 1.
REQ-021 Beats with wb=0 SHALL be consumed, drive wb_valid=0 next cycle, and still update ptr/lock/commit_count.
REQ-022 No accepted beat in cycle N -> wb_valid=0 in N+1; wb payload registers MAY hold stale values when wb_valid=0.
REQ-023 commit_count SHALL increment by 1 per accepted eop=1 beat, wrapping 2^32-1 -> 0.
REQ-024 Inputs with in_valid=1 and not granted SHALL keep in_data stable (upstream obligation); block SHALL NOT sample them.

Reset
REQ-025 While reset=0 at a clk edge: wb_valid=0, ptr=0, state=IDLE, commit_count=0, perf counter=0; in_ready SHALL be all-zero while reset=0.
REQ-026 Reset asserted mid-packet SHALL abandon the lock; first grant after release follows ptr=0 priority.

Configuration
REQ-027 Macro VX_WB_ARB_PERF_EN defined: SHALL add port perf_stalls  out  32, counting cycles where any in_valid bit is 1 and its in_ready bit is 0, saturating at 2^32-1.
REQ-028 Macro undefined: perf_stalls port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset release, all four inputs valid eop=1 wb=1 continuously -> grants 0,1,2,3,0 on consecutive cycles; wb_valid=1 from cycle 2 onward; commit_count=5 after 5 grants.
REQ-030 Input 1 sends 3-beat packet (eop on beat 3) while inputs 0,2 valid -> in_ready=0b0010 for 3 cycles, then ptr=2 and input 2 granted next.
REQ-031 Input 3 beat wb=0 eop=1 alone -> in_ready[3]=1, next cycle wb_valid=0, commit_count +1.
REQ-032 Owner of LOCKED packet drops valid 2 cycles while input 0 valid -> no grants, wb_valid=0 those cycles+1, input 0 granted only after owner eop.
REQ-033 reset=0 asserted during LOCKED beat 2 of 4 -> next cycle wb_valid=0, commit_count=0; after release input 0 wins over prior owner.
REQ-034 With VX_WB_ARB_PERF_EN: inputs 0 and 1 valid 4 cycles, 1 grant each alternately -> perf_stalls=4.
